// File: rtl/de_hazard_ctrl.sv
// Decode->Execute pipeline control for the 16-lane vector/scalar core.
// Keeps a register scoreboard, stalls decode on RAW/WAW hazards, sequences
// multi-beat vector ops through EX, flushes D/E on a taken scalar branch and
// counts decode stall cycles (saturating).
// Ports:
//   CLK, RST                      clock, async active-high reset
//   IssueValidD, RA1D, RA2D,      decode-stage instruction: sources, use flags,
//   Use1D, Use2D, WA3D,           destination, write enable, vector flag
//   RegWriteD, VecD
//   WbValidW, WA3W                writeback retirement
//   BranchTakenE                  scalar branch resolved taken in EX
//   StallF, StallD, StallE        pipeline register holds
//   FlushD, FlushE                pipeline register clears / bubble
//   VecBusyE, LaneIdxE            vector sequencer status and lane group
//   PendingMask                   scoreboard contents
//   StallCycles                   saturating count of StallD cycles
// LANES must be an integer multiple of LPC.
module de_hazard_ctrl #(
    parameter int unsigned NREG  = 16,
    parameter int unsigned LANES = 16,
    parameter int unsigned LPC   = 4,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned RIDX_W = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int unsigned NBEATS = LANES / LPC,
    localparam int unsigned LIDX_W = (NBEATS > 1) ? $clog2(NBEATS) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IssueValidD,
    input  logic [RIDX_W-1:0] RA1D,
    input  logic [RIDX_W-1:0] RA2D,
    input  logic              Use1D,
    input  logic              Use2D,
    input  logic [RIDX_W-1:0] WA3D,
    input  logic              RegWriteD,
    input  logic              VecD,
    input  logic              WbValidW,
    input  logic [RIDX_W-1:0] WA3W,
    input  logic              BranchTakenE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              VecBusyE,
    output logic [LIDX_W-1:0] LaneIdxE,
    output logic [NREG-1:0]   PendingMask,
    output logic [CNT_W-1:0]  StallCycles
);

    localparam logic [LIDX_W-1:0] LAST_BEAT = LIDX_W'(NBEATS - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        VEC_RUN = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [LIDX_W-1:0] lane_next;
    logic [NREG-1:0]   pend_rel;
    logic [NREG-1:0]   pend_next;
    logic              hz;
    logic              hold;
    logic              br;
    logic              issue;

    // Scoreboard as seen by decode: a same-cycle retirement already releases it.
    always_comb begin
        pend_rel = PendingMask;
        if (WbValidW) pend_rel[WA3W] = 1'b0;
    end

    assign hz    = IssueValidD & ((Use1D & pend_rel[RA1D]) |
                                  (Use2D & pend_rel[RA2D]) |
                                  (RegWriteD & pend_rel[WA3D]));
    assign hold  = VecBusyE & (LaneIdxE != LAST_BEAT);
    // A taken branch only acts when no vector op occupies EX.
    assign br    = BranchTakenE & ~VecBusyE;
    assign issue = IssueValidD & ~hz & ~hold & ~br;

    // Scoreboard next value: set wins over a clear of the same index.
    always_comb begin
        pend_next = pend_rel;
        if (issue && RegWriteD) pend_next[WA3D] = 1'b1;
    end

    // Vector FSM: state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            LaneIdxE <= '0;
        end else begin
            state    <= state_next;
            LaneIdxE <= lane_next;
        end
    end

    // Vector FSM: next state; the last beat lets a following vector op restart at beat 0.
    always_comb begin
        state_next = state;
        lane_next  = LaneIdxE;
        case (state)
            IDLE: begin
                if (issue && VecD) begin
                    state_next = VEC_RUN;
                    lane_next  = '0;
                end
            end
            VEC_RUN: begin
                if (LaneIdxE != LAST_BEAT) begin
                    lane_next = LaneIdxE + LIDX_W'(1);
                end else if (issue && VecD) begin
                    state_next = VEC_RUN;
                    lane_next  = '0;
                end else begin
                    state_next = IDLE;
                    lane_next  = '0;
                end
            end
            default: begin
                state_next = IDLE;
                lane_next  = '0;
            end
        endcase
    end

    // Vector FSM / hazard outputs; forced low during reset.
    always_comb begin
        VecBusyE = 1'b0;
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        if (!RST) begin
            VecBusyE = (state == VEC_RUN);
            if (br) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (hold) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
            end else if (hz) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) PendingMask <= '0;
        else     PendingMask <= pend_next;
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            StallCycles <= '0;
        end else if (StallD && (StallCycles != {CNT_W{1'b1}})) begin
            StallCycles <= StallCycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_de_hazard_ctrl.sv
module tb_de_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IssueValidD;
    logic [3:0]  RA1D, RA2D, WA3D, WA3W;
    logic        Use1D, Use2D, RegWriteD, VecD, WbValidW, BranchTakenE;
    logic        StallF, StallD, StallE, FlushD, FlushE, VecBusyE;
    logic [1:0]  LaneIdxE;
    logic [15:0] PendingMask;
    logic [15:0] StallCycles;

    int total = 0;
    int bad   = 0;

    de_hazard_ctrl dut (
        .CLK(CLK), .RST(RST),
        .IssueValidD(IssueValidD), .RA1D(RA1D), .RA2D(RA2D),
        .Use1D(Use1D), .Use2D(Use2D), .WA3D(WA3D), .RegWriteD(RegWriteD),
        .VecD(VecD), .WbValidW(WbValidW), .WA3W(WA3W), .BranchTakenE(BranchTakenE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .VecBusyE(VecBusyE),
        .LaneIdxE(LaneIdxE), .PendingMask(PendingMask), .StallCycles(StallCycles)
    );

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        IssueValidD = 0; RA1D = 0; RA2D = 0; Use1D = 0; Use2D = 0;
        WA3D = 0; RegWriteD = 0; VecD = 0; WbValidW = 0; WA3W = 0; BranchTakenE = 0;
    endtask

    // Advance one edge; inputs may be changed afterwards, checks made #1 after that.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue_write(input logic [3:0] r);
        clear_inputs();
        IssueValidD = 1; RegWriteD = 1; WA3D = r;
        tick();
        clear_inputs();
    endtask

    task automatic retire(input logic [3:0] r);
        clear_inputs();
        WbValidW = 1; WA3W = r;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        RST = 1;
        #12;
        total++;
        if ({StallF, StallD, StallE, FlushD, FlushE, VecBusyE} !== 6'b0 ||
            LaneIdxE !== 2'd0 || PendingMask !== 16'h0 || StallCycles !== 16'h0) begin
            bad++;
            $display("FAIL reset_state: ctl=%b lane=%0d pend=%h cnt=%h need all zero",
                     {StallF, StallD, StallE, FlushD, FlushE, VecBusyE}, LaneIdxE, PendingMask, StallCycles);
        end
        @(negedge CLK);
        RST = 0;
        tick();
    endtask

    task automatic test_reset_mid_vector();
        clear_inputs();
        IssueValidD = 1; VecD = 1; RegWriteD = 1; WA3D = 4'd7;
        tick();
        clear_inputs();
        tick();
        tick();
        total++;
        if (LaneIdxE !== 2'd2 || VecBusyE !== 1'b1 || StallE !== 1'b1) begin
            bad++;
            $display("FAIL vec_beat2: lane=%0d busy=%b stallE=%b need 2 1 1", LaneIdxE, VecBusyE, StallE);
        end
        // A decode hazard on r7 is also presented so combinational flush would be visible.
        IssueValidD = 1; Use1D = 1; RA1D = 4'd7;
        RST = 1;
        #1;
        total++;
        if ({StallF, StallD, StallE, FlushD, FlushE, VecBusyE} !== 6'b0 ||
            LaneIdxE !== 2'd0 || PendingMask !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid_vec: ctl=%b lane=%0d pend=%h need zero",
                     {StallF, StallD, StallE, FlushD, FlushE, VecBusyE}, LaneIdxE, PendingMask);
        end
        tick();
        clear_inputs();
        RST = 0;
        tick();
        total++;
        if (VecBusyE !== 1'b0 || PendingMask !== 16'h0 || LaneIdxE !== 2'd0 || StallCycles !== 16'h0) begin
            bad++;
            $display("FAIL after_reset_release: busy=%b pend=%h lane=%0d cnt=%h need 0 0000 0 0000",
                     VecBusyE, PendingMask, LaneIdxE, StallCycles);
        end
    endtask

    task automatic test_raw_stall();
        issue_write(4'd3);
        total++;
        if (PendingMask !== 16'h0008) begin
            bad++;
            $display("FAIL raw_set: pend=%h need 0008", PendingMask);
        end
        IssueValidD = 1; Use1D = 1; RA1D = 4'd3;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (StallD !== 1'b1 || StallF !== 1'b1 || FlushE !== 1'b1 || StallE !== 1'b0) begin
                bad++;
                $display("FAIL raw_stall cyc%0d: F=%b D=%b E=%b flushE=%b need 1 1 0 1",
                         i, StallF, StallD, StallE, FlushE);
            end
            tick();
        end
        WbValidW = 1; WA3W = 4'd3;
        #1;
        total++;
        if (StallD !== 1'b0 || FlushE !== 1'b0) begin
            bad++;
            $display("FAIL raw_release: D=%b flushE=%b need 0 0", StallD, FlushE);
        end
        tick();
        clear_inputs();
        total++;
        if (PendingMask !== 16'h0 || StallCycles !== 16'd2) begin
            bad++;
            $display("FAIL raw_after: pend=%h cnt=%0d need 0000 2", PendingMask, StallCycles);
        end
    endtask

    task automatic test_vector_seq();
        clear_inputs();
        IssueValidD = 1; VecD = 1;
        tick();
        // Scalar writer of r9 waits in D through the vector beats.
        clear_inputs();
        IssueValidD = 1; RegWriteD = 1; WA3D = 4'd9;
        for (int b = 0; b < 4; b++) begin
            total++;
            if (VecBusyE !== 1'b1 || LaneIdxE !== 2'(b) || StallE !== (b < 3) || StallD !== (b < 3)) begin
                bad++;
                $display("FAIL vec_beat%0d: busy=%b lane=%0d stallE=%b stallD=%b need 1 %0d %b %b",
                         b, VecBusyE, LaneIdxE, StallE, StallD, b, b < 3, b < 3);
            end
            tick();
        end
        clear_inputs();
        total++;
        if (VecBusyE !== 1'b0 || PendingMask !== 16'h0200 || StallCycles !== 16'd5) begin
            bad++;
            $display("FAIL vec_scalar_issue: busy=%b pend=%h cnt=%0d need 0 0200 5",
                     VecBusyE, PendingMask, StallCycles);
        end
        retire(4'd9);
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        IssueValidD = 1; VecD = 1;
        tick();
        // Second vector op waits; a taken branch during the run must be ignored.
        BranchTakenE = 1;
        tick();
        total++;
        if (FlushD !== 1'b0 || FlushE !== 1'b0 || StallD !== 1'b1) begin
            bad++;
            $display("FAIL branch_in_vec: flushD=%b flushE=%b stallD=%b need 0 0 1", FlushD, FlushE, StallD);
        end
        BranchTakenE = 0;
        tick();
        tick();
        tick();
        clear_inputs();
        total++;
        if (VecBusyE !== 1'b1 || LaneIdxE !== 2'd0) begin
            bad++;
            $display("FAIL back_to_back: busy=%b lane=%0d need 1 0", VecBusyE, LaneIdxE);
        end
        repeat (4) tick();
        total++;
        if (VecBusyE !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: busy=%b need 0", VecBusyE);
        end
    endtask

    task automatic test_branch_flush();
        issue_write(4'd4);
        IssueValidD = 1; Use2D = 1; RA2D = 4'd4; RegWriteD = 1; WA3D = 4'd6;
        BranchTakenE = 1;
        #1;
        total++;
        if (FlushD !== 1'b1 || FlushE !== 1'b1 || StallD !== 1'b0 || StallF !== 1'b0) begin
            bad++;
            $display("FAIL branch_flush: flushD=%b flushE=%b D=%b F=%b need 1 1 0 0",
                     FlushD, FlushE, StallD, StallF);
        end
        tick();
        clear_inputs();
        total++;
        if (PendingMask !== 16'h0010) begin
            bad++;
            $display("FAIL branch_pend: pend=%h need 0010", PendingMask);
        end
    endtask

    task automatic test_set_clear_same();
        issue_write(4'd5);
        WbValidW = 1; WA3W = 4'd5;
        IssueValidD = 1; RegWriteD = 1; WA3D = 4'd5;
        #1;
        total++;
        if (StallD !== 1'b0) begin
            bad++;
            $display("FAIL waw_release: stallD=%b need 0", StallD);
        end
        tick();
        clear_inputs();
        total++;
        if (PendingMask !== 16'h0030) begin
            bad++;
            $display("FAIL set_wins: pend=%h need 0030", PendingMask);
        end
        retire(4'd4);
        retire(4'd5);
        total++;
        if (PendingMask !== 16'h0) begin
            bad++;
            $display("FAIL sb_cleared: pend=%h need 0000", PendingMask);
        end
    endtask

    task automatic test_saturation();
        issue_write(4'd2);
        IssueValidD = 1; Use1D = 1; RA1D = 4'd2;
        repeat (65536 + 10) tick();
        total++;
        if (StallCycles !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_reach: cnt=%h need ffff", StallCycles);
        end
        repeat (20) tick();
        total++;
        if (StallCycles !== 16'hFFFF || StallD !== 1'b1) begin
            bad++;
            $display("FAIL sat_hold: cnt=%h stallD=%b need ffff 1", StallCycles, StallD);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_reset_mid_vector();
        test_raw_stall();
        test_vector_seq();
        test_back_to_back();
        test_branch_flush();
        test_set_clear_same();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
